// File: rtl/handshake_bus_sync.sv
// -----------------------------------------------------------------------------
// handshake_bus_sync
//
// Destination-side controller for a toggle-handshake multi-bit clock-domain
// crossing. The source toggles req_tgl once per word while holding unsync_bus
// stable. This block synchronizes req_tgl through an N_flop-stage chain and
// detects its level change. It then captures unsync_bus into a holding
// register and offers the word to a local consumer with valid/ready. ack_tgl
// toggles back to the source only after the consumer accepts the word.
//
// Parameters
//   data_width  width of the transferred bus
//   N_flop      synchronizer depth on req_tgl (must be >= 2)
//
// Ports
//   clk          destination-domain clock
//   rst          asynchronous, active-high reset
//   unsync_bus   source-domain data, quasi-static while a word is outstanding
//   req_tgl      source request toggle (each level change = one new word)
//   ack_tgl      acknowledge toggle back to source, one change per accepted word
//   sync_bus     captured word, meaningful while sync_valid = 1
//   sync_valid   holding register occupied
//   sync_ready   consumer accepts sync_bus when sync_valid & sync_ready
//   overrun      sticky flag: new request arrived while a word was still held
//   clr_overrun  synchronous clear of overrun (a same-cycle violation wins)
// -----------------------------------------------------------------------------
module handshake_bus_sync #(
  parameter int data_width = 8,
  parameter int N_flop     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] unsync_bus,
  input  logic                  req_tgl,
  output logic                  ack_tgl,
  output logic [data_width-1:0] sync_bus,
  output logic                  sync_valid,
  input  logic                  sync_ready,
  output logic                  overrun,
  input  logic                  clr_overrun
);

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_e;

  logic [N_flop-1:0]     stage_q;
  logic                  hist_q;
  logic                  req_edge_s;
  logic                  violation_s;

  state_e                state_q;
  state_e                state_d;
  logic [data_width-1:0] bus_q;
  logic [data_width-1:0] bus_d;
  logic                  valid_q;
  logic                  valid_d;
  logic                  ack_q;
  logic                  ack_d;
  logic                  ovr_q;
  logic                  ovr_d;

  // Synchronizer chain plus history flop. Only stage_q[0] sees the
  // asynchronous req_tgl. The bus itself is never routed through the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= {N_flop{1'b0}};
      hist_q  <= 1'b0;
    end else begin
      stage_q <= {stage_q[N_flop-2:0], req_tgl};
      hist_q  <= stage_q[N_flop-1];
    end
  end

  // Any level change at the synchronizer output marks one new word.
  assign req_edge_s  = stage_q[N_flop-1] ^ hist_q;
  // A new word while one is still held is dropped and only flagged.
  assign violation_s = req_edge_s & (state_q == FULL);

  // Next-state, capture, acknowledge and overrun logic.
  always_comb begin
    state_d = state_q;
    bus_d   = bus_q;
    valid_d = valid_q;
    ack_d   = ack_q;
    // Set has priority over clear so that no violation is ever lost.
    ovr_d   = violation_s ? 1'b1 : (clr_overrun ? 1'b0 : ovr_q);

    case (state_q)
      IDLE: begin
        if (req_edge_s) begin
          bus_d   = unsync_bus;
          valid_d = 1'b1;
          state_d = FULL;
        end else begin
          state_d = IDLE;
        end
      end
      FULL: begin
        if (sync_ready) begin
          // The word stays on sync_bus after acceptance; only valid drops.
          valid_d = 1'b0;
          ack_d   = ~ack_q;
          state_d = IDLE;
        end else begin
          state_d = FULL;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Every output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bus_q   <= {data_width{1'b0}};
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bus_q   <= bus_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sync_bus   = bus_q;
  assign sync_valid = valid_q;
  assign ack_tgl    = ack_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_handshake_bus_sync.sv
module tb_handshake_bus_sync;

  logic        clk;
  logic        rst;
  logic [7:0]  unsync_bus;
  logic        req_tgl;
  logic        ack_tgl;
  logic [7:0]  sync_bus;
  logic        sync_valid;
  logic        sync_ready;
  logic        overrun;
  logic        clr_overrun;

  // Second instance for the wider / deeper parameter set
  logic [15:0] p_bus;
  logic        p_req;
  logic        p_ack;
  logic [15:0] p_sbus;
  logic        p_valid;
  logic        p_ready;
  logic        p_ovr;
  logic        p_clr;

  int          total;
  int          bad;
  int          n_sent;
  int          n_acc;
  logic [7:0]  exp_q[$];

  handshake_bus_sync #(.data_width(8), .N_flop(2)) dut (
    .clk(clk), .rst(rst), .unsync_bus(unsync_bus), .req_tgl(req_tgl),
    .ack_tgl(ack_tgl), .sync_bus(sync_bus), .sync_valid(sync_valid),
    .sync_ready(sync_ready), .overrun(overrun), .clr_overrun(clr_overrun)
  );

  handshake_bus_sync #(.data_width(16), .N_flop(3)) dut_p (
    .clk(clk), .rst(rst), .unsync_bus(p_bus), .req_tgl(p_req),
    .ack_tgl(p_ack), .sync_bus(p_sbus), .sync_valid(p_valid),
    .sync_ready(p_ready), .overrun(p_ovr), .clr_overrun(p_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Source model: obeys the contract (one word outstanding, bus held until ack)
  task automatic send(input logic [7:0] w);
    unsync_bus = w;
    req_tgl    = ~req_tgl;
    exp_q.push_back(w);
    n_sent++;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (ack_tgl == req_tgl) break;
    end
    check("ack_returned", {31'd0, ack_tgl}, {31'd0, req_tgl});
  endtask

  // Scoreboard monitor: each acceptance must deliver the oldest outstanding word
  always @(negedge clk) begin
    if (!rst && sync_valid && sync_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got 0x%0h, expected no word", sync_bus);
      end else begin
        check("scoreboard_word", {24'd0, sync_bus}, {24'd0, exp_q.pop_front()});
        n_acc++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic done;
    total = 0; bad = 0; n_sent = 0; n_acc = 0;
    rst = 1'b1; unsync_bus = 8'h00; req_tgl = 1'b0; sync_ready = 1'b0; clr_overrun = 1'b0;
    p_bus = 16'h0000; p_req = 1'b0; p_ready = 1'b0; p_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_valid", {31'd0, sync_valid}, 32'd0);
    check("rst_ack",   {31'd0, ack_tgl},    32'd0);
    check("rst_ovr",   {31'd0, overrun},    32'd0);
    check("rst_bus",   {24'd0, sync_bus},   32'd0);
    tick();

    // Single transfer with exact latency
    unsync_bus = 8'hA5; req_tgl = 1'b1; sync_ready = 1'b1;
    exp_q.push_back(8'hA5);
    tick(); tick();
    check("lat_e2_valid", {31'd0, sync_valid}, 32'd0);
    tick();
    check("lat_e3_valid", {31'd0, sync_valid}, 32'd1);
    check("lat_e3_bus",   {24'd0, sync_bus},   32'hA5);
    tick();
    check("e4_valid", {31'd0, sync_valid}, 32'd0);
    check("e4_ack",   {31'd0, ack_tgl},    32'd1);
    check("e4_ovr",   {31'd0, overrun},    32'd0);

    // Backpressure
    sync_ready = 1'b0; unsync_bus = 8'h3C; req_tgl = 1'b0;
    exp_q.push_back(8'h3C);
    repeat (3) tick();
    check("bp_capture", {31'd0, sync_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", {31'd0, sync_valid}, 32'd1);
      check("bp_hold_bus",   {24'd0, sync_bus},   32'h3C);
      check("bp_hold_ack",   {31'd0, ack_tgl},    32'd1);
    end
    sync_ready = 1'b1;
    tick();
    check("bp_accept_valid", {31'd0, sync_valid}, 32'd0);
    check("bp_accept_ack",   {31'd0, ack_tgl},    32'd0);
    check("bp_bus_kept",     {24'd0, sync_bus},   32'h3C);

    // Back-to-back words, each after the previous ack
    send(8'h01); send(8'h02); send(8'h03);
    check("b2b_ack_end", {31'd0, ack_tgl}, 32'd1);
    check("b2b_ovr",     {31'd0, overrun}, 32'd0);
    check("b2b_drained", exp_q.size(),     32'd0);

    // Overrun: new toggle while 0x11 is held
    sync_ready = 1'b0; unsync_bus = 8'h11; req_tgl = ~req_tgl;
    exp_q.push_back(8'h11);
    repeat (3) tick();
    check("ovr_capture", {24'd0, sync_bus}, 32'h11);
    unsync_bus = 8'h22; req_tgl = ~req_tgl;
    repeat (3) tick();
    check("ovr_set",       {31'd0, overrun},    32'd1);
    check("ovr_bus_kept",  {24'd0, sync_bus},   32'h11);
    check("ovr_valid",     {31'd0, sync_valid}, 32'd1);
    check("ovr_no_ack",    {31'd0, ack_tgl},    32'd1);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("ovr_cleared", {31'd0, overrun}, 32'd0);
    req_tgl = ~req_tgl;
    tick(); tick();
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("ovr_set_wins", {31'd0, overrun}, 32'd1);
    check("ovr_bus_kept2", {24'd0, sync_bus}, 32'h11);
    sync_ready = 1'b1;
    tick();
    check("ovr_accept_ack", {31'd0, ack_tgl}, 32'd0);
    check("ovr_drained",    exp_q.size(),     32'd0);

    // Reset mid-transfer
    sync_ready = 1'b0; unsync_bus = 8'h77; req_tgl = ~req_tgl;
    exp_q.push_back(8'h77);
    repeat (3) tick();
    check("mid_full", {31'd0, sync_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, sync_valid}, 32'd0);
    check("mid_rst_bus",   {24'd0, sync_bus},   32'd0);
    check("mid_rst_ack",   {31'd0, ack_tgl},    32'd0);
    check("mid_rst_ovr",   {31'd0, overrun},    32'd0);
    exp_q.delete();
    req_tgl = 1'b0;
    tick(); tick();
    rst = 1'b0;
    sync_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_quiet", {31'd0, sync_valid}, 32'd0);
    end

    // Randomized traffic with random consumer backpressure
    n_sent = 0; n_acc = 0; done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(8'($urandom_range(0, 255)));
          repeat ($urandom_range(0, 3)) tick();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          tick();
          sync_ready = ($urandom_range(0, 9) < 6);
        end
      end
    join
    sync_ready = 1'b1;
    repeat (4) tick();
    check("rand_drained",  exp_q.size(),     32'd0);
    check("rand_count",    n_acc,            n_sent);
    check("rand_no_ovr",   {31'd0, overrun}, 32'd0);
    check("rand_ack_sync", {31'd0, ack_tgl}, {31'd0, req_tgl});

    // Parameter sweep: N_flop=3, data_width=16
    p_bus = 16'hBEEF; p_req = 1'b1; p_ready = 1'b1;
    repeat (3) tick();
    check("p_e3_valid", {31'd0, p_valid}, 32'd0);
    tick();
    check("p_e4_valid", {31'd0, p_valid}, 32'd1);
    check("p_e4_bus",   {16'd0, p_sbus},  32'hBEEF);
    tick();
    check("p_e5_valid", {31'd0, p_valid}, 32'd0);
    check("p_e5_ack",   {31'd0, p_ack},   32'd1);
    check("p_ovr",      {31'd0, p_ovr},   32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
